// File: rtl/pointer_step_arbiter.sv
// pointer_step_arbiter
// Round-robin arbiter that turns per-requester up/down requests into
// single-cycle increment/decrement pulses for a shared pointer register,
// and keeps a shadow copy of that pointer in ptr_value.
// Every grant occupies two cycles (PULSE or REJECT, then IDLE), so step
// pulses are always separated by at least one low cycle.
// Optional feature: define PTR_BOUNDS_CHECK_EN to reject steps that would
// wrap the pointer past 0 or 2^WIDTH-1; rejected grants pulse err instead.
module pointer_step_arbiter #(
  parameter int                 WIDTH     = 16,
  parameter int                 N_REQ     = 4,
  parameter int                 STEP      = 2,
  parameter logic [WIDTH-1:0]   RESET_VAL = '1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_REQ-1:0]  req,
  input  logic [N_REQ-1:0]  dir,
  output logic [N_REQ-1:0]  grant,
  output logic              inc_pulse,
  output logic              dec_pulse,
  output logic [WIDTH-1:0]  ptr_value,
  output logic              busy,
  output logic              err
);

  localparam int               PW     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PULSE  = 2'd1,
    REJECT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [PW-1:0]       prio_q, prio_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic                inc_q, inc_d;
  logic                dec_q, dec_d;
  logic                busy_q, busy_d;
  logic [WIDTH-1:0]    ptr_q, ptr_d;

  logic                found;
  logic [PW-1:0]       winner;
  logic                win_dir;
  logic                reject;

  // Round-robin search starting at the current highest-priority requester
  always_comb begin : arbitrate
    // NOTE: every variable written here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int idx;
      idx = (int'(prio_q) + k) % N_REQ;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = PW'(idx);
      end
    end
  end

  assign win_dir = dir[winner];

`ifdef PTR_BOUNDS_CHECK_EN
  localparam logic [WIDTH-1:0] UP_LIMIT = {WIDTH{1'b1}} - STEP_W;
  localparam logic [WIDTH-1:0] DN_LIMIT = STEP_W;

  logic err_q, err_d;

  // A step that would cross the pointer's range boundary is refused
  assign reject = win_dir ? (ptr_q > UP_LIMIT) : (ptr_q < DN_LIMIT);
`else
  assign reject = 1'b0;
`endif

  // State register and all registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      prio_q  <= '0;
      grant_q <= '0;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
      busy_q  <= 1'b0;
      ptr_q   <= RESET_VAL;
`ifdef PTR_BOUNDS_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples its _d value from before this edge, independent of order.
      state_q <= state_d;
      prio_q  <= prio_d;
      grant_q <= grant_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
`ifdef PTR_BOUNDS_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  // Next state: arbitrate only from IDLE; PULSE and REJECT last one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found) state_d = reject ? REJECT : PULSE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath values loaded at the arbitration edge
  always_comb begin
    grant_d = '0;
    inc_d   = 1'b0;
    dec_d   = 1'b0;
    ptr_d   = ptr_q;
    prio_d  = prio_q;
`ifdef PTR_BOUNDS_CHECK_EN
    err_d   = 1'b0;
`endif
    if (state_q == IDLE && found) begin
      grant_d = N_REQ'(1) << winner;
      prio_d  = (winner == PW'(N_REQ - 1)) ? '0 : winner + PW'(1);
      if (!reject) begin
        if (win_dir) begin
          inc_d = 1'b1;
          ptr_d = ptr_q + STEP_W;
        end else begin
          dec_d = 1'b1;
          ptr_d = ptr_q - STEP_W;
        end
      end else begin
`ifdef PTR_BOUNDS_CHECK_EN
        err_d = 1'b1;
`endif
      end
    end
    busy_d = (state_d != IDLE);
  end

  assign grant     = grant_q;
  assign inc_pulse = inc_q;
  assign dec_pulse = dec_q;
  assign ptr_value = ptr_q;
  assign busy      = busy_q;
`ifdef PTR_BOUNDS_CHECK_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_pointer_step_arbiter.sv
// Self-checking bench for pointer_step_arbiter: directed scenarios plus
// randomized traffic, checked by a scoreboard fed from a behavioural model.
module tb_pointer_step_arbiter;

  localparam int WIDTH = 16;
  localparam int N_REQ = 4;
  localparam int STEP  = 2;
  localparam int MODV  = 1 << WIDTH;
  localparam int RVAL  = MODV - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [N_REQ-1:0]  req = '0;
  logic [N_REQ-1:0]  dir = '0;
  logic [N_REQ-1:0]  grant;
  logic              inc_pulse, dec_pulse, busy, err;
  logic [WIDTH-1:0]  ptr_value;

  pointer_step_arbiter #(
    .WIDTH(WIDTH), .N_REQ(N_REQ), .STEP(STEP)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .dir(dir), .grant(grant),
    .inc_pulse(inc_pulse), .dec_pulse(dec_pulse), .ptr_value(ptr_value),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int grant_idx;
    bit inc;
    bit dec;
    bit err;
    int ptr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input longint act, input longint req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req_v, $time);
    end
  endtask

  // Behavioural model: a grant takes two cycles, winner is the first
  // requester at or after the priority index, pointer moves by +/-STEP.
  int m_prio = 0;
  int m_ptr  = RVAL;
  bit m_busy = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_prio = 0;
      m_ptr  = RVAL;
      m_busy = 0;
      exp_q.delete();
    end else if (m_busy) begin
      m_busy = 0;
    end else if (req != 0) begin
      exp_t e;
      int w;
      bit rej;
      w = -1;
      for (int k = 0; k < N_REQ; k++)
        if (w < 0 && req[(m_prio + k) % N_REQ]) w = (m_prio + k) % N_REQ;
      rej = 0;
`ifdef PTR_BOUNDS_CHECK_EN
      if (dir[w]) rej = (m_ptr + STEP > MODV - 1);
      else        rej = (m_ptr < STEP);
`endif
      if (!rej) m_ptr = dir[w] ? (m_ptr + STEP) % MODV : (m_ptr - STEP + MODV) % MODV;
      e.grant_idx = w;
      e.inc = !rej && dir[w];
      e.dec = !rej && !dir[w];
      e.err = rej;
      e.ptr = m_ptr;
      exp_q.push_back(e);
      m_prio = (w + 1) % N_REQ;
      m_busy = 1;
    end
  end

  // Monitor: safety properties every cycle, scoreboard pop on each grant
  bit prev_pulse = 0;
  always @(negedge clk) begin
    if (!reset) begin
      prev_pulse = 0;
    end else begin
      check("inc_and_dec", inc_pulse & dec_pulse, 0);
      check("back_to_back", (inc_pulse | dec_pulse) & prev_pulse, 0);
      prev_pulse = inc_pulse | dec_pulse;
      check("grant_onehot0", $onehot0(grant), 1);
      check("busy_vs_grant", busy, grant != 0);
      check("ptr_track", ptr_value, m_ptr);
      if (grant != 0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_grant", grant, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_grant", grant, 1 << e.grant_idx);
          check("sb_pulses", {inc_pulse, dec_pulse, err}, {e.inc, e.dec, e.err});
          check("sb_ptr", ptr_value, e.ptr);
        end
      end else begin
        check("idle_quiet", {inc_pulse, dec_pulse, err}, 0);
      end
    end
  end

  logic [N_REQ-1:0] seen_q[$];
  int               seen_cyc[$];

  // Run n cycles; hold=0 drops a requester's req once it is granted
  task automatic run_cycles(input int n, input bit hold);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (grant != 0) begin
        seen_q.push_back(grant);
        seen_cyc.push_back(c);
        if (!hold) req = req & ~grant;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req = '0;
    dir = '0;
    repeat (2) @(negedge clk);
    check("rst_outputs", {grant, inc_pulse, dec_pulse, busy, err}, 0);
    check("rst_ptr", ptr_value, RVAL);
    reset = 1'b1;
  endtask

  initial begin
    int busy_cnt;
    int waited;

    do_reset();

    // Single up request from reset
    req = 4'b0001; dir = 4'b0001;
    seen_q.delete(); seen_cyc.delete();
    run_cycles(4, 0);
    check("up_grant_count", seen_q.size(), 1);
    if (seen_q.size() > 0) check("up_grant", seen_q[0], 4'b0001);
`ifdef PTR_BOUNDS_CHECK_EN
    check("up_ptr", ptr_value, RVAL);
`else
    check("up_ptr", ptr_value, 1);
`endif

    // Single down request from reset; busy high exactly one cycle
    do_reset();
    req = 4'b0001; dir = 4'b0000;
    busy_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (grant != 0) req = req & ~grant;
    end
    check("down_busy_cycles", busy_cnt, 1);
    check("down_ptr", ptr_value, RVAL - 2);

    // All four held, all down: rotation every second cycle
    do_reset();
    req = 4'b1111; dir = 4'b0000;
    seen_q.delete(); seen_cyc.delete();
    run_cycles(10, 1);
    req = '0;
    check("rr_grant_count", seen_q.size(), 5);
    for (int i = 0; i < 5 && i < seen_q.size(); i++) begin
      logic [N_REQ-1:0] exp_g;
      exp_g = N_REQ'(1) << (i % N_REQ);
      check("rr_order", seen_q[i], exp_g);
      if (i > 0) check("rr_spacing", seen_cyc[i] - seen_cyc[i-1], 2);
    end
    check("rr_ptr", ptr_value, RVAL - 10);
    run_cycles(3, 0);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (grant != 0) req = req & ~grant;
      for (int i = 0; i < N_REQ; i++) begin
        if (!req[i] && !grant[i] && $urandom_range(2) == 0) begin
          req[i] = 1'b1;
          dir[i] = 1'($urandom_range(1));
        end
      end
    end
    req = '0;
    run_cycles(4, 0);
    check("random_drain", exp_q.size(), 0);

    // Reset in the middle of a pulse
    req = 4'b0100; dir = 4'b0100;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!(inc_pulse | dec_pulse) && waited < 10);
    check("mid_pulse_seen", inc_pulse | dec_pulse, 1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_pulses", {inc_pulse, dec_pulse, grant, busy}, 0);
    check("mid_rst_ptr", ptr_value, RVAL);
    req = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    req = 4'b1111; dir = 4'b1111;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (grant == 0 && waited < 10);
    check("post_rst_grant", grant, 4'b0001);
    req = '0;
    run_cycles(4, 0);
    check("final_drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
